// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that time-shares one external combinational ALU.
// Each operation runs IDLE (grant/capture) -> EXEC (drive ALU) -> RESP (hold result).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_SrcA,
    output logic [WIDTH-1:0] alu_SrcB,
    output logic [2:0]       alu_ALUControl,
    input  logic [WIDTH-1:0] alu_ALUResult,
    input  logic             alu_Zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic             w_any_valid;
    logic             w_grant;
    logic             w_rsp_done;

    // Round-robin pick: on contention the port that did not win last time goes next.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
        w_rsp_done = r_owner ? rsp1_ready : rsp0_ready;
    end

    // Ready is forced low while reset is being sampled so no transfer is advertised.
    assign req0_ready = rst_n & (r_state == S_IDLE) & req0_valid & ~w_grant;
    assign req1_ready = rst_n & (r_state == S_IDLE) & req1_valid & w_grant;

    // Sequencer state, operand capture, result register and response flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_a          <= {WIDTH{1'b0}};
            r_b          <= {WIDTH{1'b0}};
            r_op         <= 3'd0;
            r_result     <= {WIDTH{1'b0}};
            r_zero       <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_a          <= w_grant ? req1_a  : req0_a;
                        r_b          <= w_grant ? req1_b  : req0_b;
                        r_op         <= w_grant ? req1_op : req0_op;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result     <= alu_ALUResult;
                    r_zero       <= alu_Zero;
                    r_rsp0_valid <= ~r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // The ALU only ever sees registered operands, never the live request buses.
    assign alu_SrcA       = r_a;
    assign alu_SrcB       = r_b;
    assign alu_ALUControl = r_op;

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU closes the loop on the alu_* port.
module tb_alu_arbiter;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic [31:0] alu_SrcA, alu_SrcB, alu_ALUResult;
    logic [2:0]  alu_ALUControl;
    logic        alu_Zero;

    int n_checks;
    int n_fail;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_SrcA(alu_SrcA), .alu_SrcB(alu_SrcB), .alu_ALUControl(alu_ALUControl),
        .alu_ALUResult(alu_ALUResult), .alu_Zero(alu_Zero)
    );

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        case (alu_ALUControl)
            OP_ADD:  alu_ALUResult = alu_SrcA + alu_SrcB;
            OP_SUB:  alu_ALUResult = alu_SrcA - alu_SrcB;
            OP_AND:  alu_ALUResult = alu_SrcA & alu_SrcB;
            OP_OR:   alu_ALUResult = alu_SrcA | alu_SrcB;
            OP_XOR:  alu_ALUResult = alu_SrcA ^ alu_SrcB;
            OP_SLL:  alu_ALUResult = alu_SrcA << alu_SrcB[4:0];
            OP_SRL:  alu_ALUResult = alu_SrcA >> alu_SrcB[4:0];
            OP_SLT:  alu_ALUResult = {31'd0, ($signed(alu_SrcA) < $signed(alu_SrcB))};
            default: alu_ALUResult = 32'd0;
        endcase
        alu_Zero = (alu_ALUResult == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One isolated operation on a single port with rsp_ready held high.
    task automatic do_op(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] exp_res, input logic exp_zero);
        @(negedge clk);
        if (port == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        #1;
        chk("req_ready_granted", {31'd0, (port == 0) ? req0_ready : req1_ready}, 32'd1);
        chk("req_ready_other",   {31'd0, (port == 0) ? req1_ready : req0_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("exec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, (port == 0) ? 32'd1 : 32'd2);
        chk("rsp_result", (port == 0) ? rsp0_result : rsp1_result, exp_res);
        chk("rsp_zero", {31'd0, (port == 0) ? rsp0_zero : rsp1_zero}, {31'd0, exp_zero});
        @(posedge clk); #1;
        chk("rsp_done", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req0_op = 3'd0;
        req1_a = 32'd0; req1_b = 32'd0; req1_op = 3'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset: ready suppressed while rst_n low, everything zeroed.
        @(posedge clk); #1;
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_alu_a", alu_SrcA, 32'd0);
        chk("rst_result", rsp0_result, 32'd0);
        req0_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        do_op(0, 32'd10, 32'd5, OP_ADD, 32'd15, 1'b0);
        do_op(1, 32'd10, 32'd10, OP_SUB, 32'd0, 1'b1);
        do_op(1, 32'd5, 32'd10, OP_SLT, 32'd1, 1'b0);
        do_op(1, 32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1, 1'b0);

        // Continuous contention: grants must alternate 0,1,0,1 at 3 cycles each.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'h0F0F_0F0F; req0_op = OP_AND;
        req1_valid = 1'b1; req1_a = 32'hAAAA_5555; req1_b = 32'h5555_AAAA; req1_op = OP_OR;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("cont_ready", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk); #1;
            chk("cont_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk); #1;
            chk("cont_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_result", (k % 2 == 0) ? rsp0_result : rsp1_result,
                (k % 2 == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF);
            chk("cont_zero", {31'd0, (k % 2 == 0) ? rsp0_zero : rsp1_zero},
                (k % 2 == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure on port 0 with both requesters knocking.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h8765_4321; req0_op = OP_XOR;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("bp_result", rsp0_result, 32'h9551_1559);
            chk("bp_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_done", {31'd0, rsp0_valid}, 32'd0);
        req1_valid = 1'b1; #1;
        chk("bp_idle_ready", {31'd0, req1_ready}, 32'd1);
        req1_valid = 1'b0;

        do_op(0, 32'd1, 32'd3, OP_SLL, 32'd8, 1'b0);
        do_op(0, 32'd8, 32'd2, OP_SRL, 32'd2, 1'b0);
        do_op(0, 32'd1, 32'h23, OP_SLL, 32'd8, 1'b0);

        // Reset while in EXEC.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_op = OP_ADD;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_exec_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_exec_alu_a", alu_SrcA, 32'd0);
        chk("rst_exec_alu_op", {29'd0, alu_ALUControl}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_exec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        // Reset while in RESP, response stalled so only reset can clear it.
        rsp0_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = OP_ADD;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_resp", {31'd0, rsp0_valid}, 32'd1);
        chk("pre_rst_result", rsp0_result, 32'd7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_resp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_resp_result", rsp0_result, 32'd0);
        chk("rst_resp_zero", {31'd0, rsp0_zero}, 32'd0);
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_resp_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        // Port 0 won last before reset; reset must hand the next contention to port 0 again.
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        chk("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one combinational `alu` instance between two requesters. It sits between the execute-stage issue logic (port 0) and the address/branch-compare unit (port 1). For each request it performs:
- operand capture,
- drive of the shared ALU,
- result registration,
- handshaked return of ALUResult/Zero to the requester that issued the operation.

One operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the instantiated `alu`.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- req0_valid / req1_valid  in  1  requester n presents an operation.
- req0_ready / req1_ready  out  1  arbiter accepts port n this cycle (transfer = valid & ready).
- req0_a / req1_a  in  WIDTH  operand A (maps to SrcA).
- req0_b / req1_b  in  WIDTH  operand B (maps to SrcB; shifts use b[4:0]).
- req0_op / req1_op  in  3  ALUControl code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT (signed).
- rsp0_valid / rsp1_valid  out  1  result available on port n.
- rsp0_ready / rsp1_ready  in  1  requester n consumes result.
- rsp0_result / rsp1_result  out  WIDTH  registered ALUResult.
- rsp0_zero / rsp1_zero  out  1  registered Zero (result == 0).
- alu_SrcA, alu_SrcB  out  WIDTH  to shared ALU.
- alu_ALUControl  out  3  to shared ALU.
- alu_ALUResult  in  WIDTH  from shared ALU.
- alu_Zero  in  1  from shared ALU.

## Operation
FSM states: IDLE, EXEC, RESP.

IDLE:
- Grant selection:
  - Only one reqN_valid: grant port N.
  - Both valid: grant the port that is not last_grant.
  - No valid: stay in IDLE.
- reqN_ready = (state==IDLE) & grant==N. This is combinational from the valids. The ready of the non-granted port is 0.
- On transfer:
  - Capture a, b, op into operand registers.
  - Record owner = N and last_grant = N.
  - Go to EXEC.
- Requesters hold valid/a/b/op stable until ready. Deasserting valid before the transfer withdraws the request, with no side effect.

EXEC (exactly one cycle):
- alu_SrcA/alu_SrcB/alu_ALUControl are driven from the operand registers.
- At the end of the cycle, alu_ALUResult and alu_Zero are registered into the result register.
- Go to RESP.

RESP:
- rsp<owner>_valid = 1. The other port's rsp_valid = 0.
- rsp<owner>_result/zero are held stable until rsp<owner>_ready.
- On rsp<owner>_valid & rsp<owner>_ready: go to IDLE.
- rsp_ready on the non-owner port is ignored.

ALU drive outside EXEC:
- ALU inputs are held at the operand register values.
- No combinational path from req* to alu_*.

Both rspN_result/zero ports show the result register; only rsp_valid qualifies them.

Arithmetic is performed entirely by the ALU. The arbiter never alters operands or results.

## Timing
Reset (rst_n=0 at a clock edge), taking effect the same edge:
- state = IDLE, last_grant = 1 (port 0 wins the first contention).
- Operand and result registers = 0; owner = 0.
- All reqN_ready = 0 during the reset cycle; all rspN_valid = 0.
- alu_* = 0; rspN_result = 0; rspN_zero = 0.

Reset mid-operation (EXEC or RESP):
- The in-flight operation is discarded.
- No response is delivered after reset is released.

Latency: request transfer at edge T produces rsp_valid high from cycle T+2 (transfer cycle, then EXEC, then RESP).

Minimum issue interval: 3 cycles per operation when rsp_ready is already high in RESP.

Back-pressure: rsp_ready low stalls in RESP indefinitely. Both req_ready stay 0 throughout.

Fairness: under continuous contention, grants alternate 0,1,0,1,…

A new request and a response handshake may occur on the same edge only for different operations. The response completes into IDLE; a request is accepted no earlier than the next cycle.

## Test plan
- Reset, then port 0 only: ADD a=10, b=5.
  - req0_ready high in the request cycle.
  - rsp0_valid 2 cycles after transfer with result=15, zero=0.
  - rsp1_valid stays 0.
- Port 1 only: SUB a=10, b=10.
  - rsp1_result=0, rsp1_zero=1.
  - Then SLT a=5, b=10 gives result=1.
  - Then SLT a=-1 (0xFFFFFFFF), b=1 gives result=1.
- Both valid continuously, port 0 AND 0xF0F0F0F0 & 0x0F0F0F0F and port 1 OR 0xAAAA5555 | 0x5555AAAA:
  - Grants go 0, 1, 0, 1.
  - Port 0 returns result 0 with zero=1; port 1 returns 0xFFFFFFFF.
  - Each operation takes 3 cycles.
- Back-pressure on port 0:
  - Request XOR 0x12345678 ^ 0x87654321 with rsp0_ready=0 for 5 cycles.
  - rsp0_valid is held with result 0x95511559 stable, and both req_ready stay 0.
  - rsp0_ready high completes the transfer; return to IDLE next cycle.
- Shifts:
  - SLL a=1, b=3 gives 8.
  - SRL a=8, b=2 gives 2.
  - SLL a=1, b=0x23 gives 8 (b[4:0] only).
- Reset mid-operation:
  - Assert rst_n=0 in EXEC and again in RESP.
  - All outputs take their reset values at the next edge, and no rsp_valid appears after release.
  - The next contention is granted to port 0.
